// File: rtl/gf180mcu_fd_sc_mcu9t5v0__andn_pkg.sv
// gf180mcu_fd_sc_mcu9t5v0__andn_pkg: shared mode encodings and tree-sizing helpers
package gf180mcu_fd_sc_mcu9t5v0__andn_pkg;
  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_NAND = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_NACC = 2'b11
  } mode_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  // operand count entering tree level lvl
  function automatic int lvl_n(input int nin, input int lvl);
    int n;
    n = nin;
    for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__andn_stage.sv
// gf180mcu_fd_sc_mcu9t5v0__andn_stage: one pairwise-AND tree level with optional register and valid/mode sideband
module gf180mcu_fd_sc_mcu9t5v0__andn_stage
  import gf180mcu_fd_sc_mcu9t5v0__andn_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int N     = 2,
  parameter bit REG   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_i,
  input  logic [N*WIDTH-1:0]            a_i,
  input  logic                          valid_i,
  input  mode_e                         mode_i,
  output logic [((N+1)/2)*WIDTH-1:0]    z_o,
  output logic                          valid_o,
  output mode_e                         mode_o
);
  localparam int NP = N / 2;
  localparam int NO = (N + 1) / 2;
  logic [NO*WIDTH-1:0] z_d, z_q;
  logic valid_q;
  mode_e mode_q;
  always_comb begin
    z_d = '0;
    for (int k = 0; k < NP; k++) z_d[k*WIDTH +: WIDTH] = a_i[2*k*WIDTH +: WIDTH] & a_i[(2*k+1)*WIDTH +: WIDTH];
    if (N % 2 == 1) z_d[NP*WIDTH +: WIDTH] = a_i[(N-1)*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      z_q <= '0;
      valid_q <= 1'b0;
      mode_q <= MODE_AND;
    end else if (en_i) begin
      z_q <= z_d;
      valid_q <= valid_i;
      mode_q <= valid_i ? mode_i : mode_q;
    end
  // unregistered levels simply bypass the flops, which then have no load
  assign z_o = REG ? z_q : z_d;
  assign valid_o = REG ? valid_q : valid_i;
  assign mode_o = REG ? mode_q : mode_i;
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__andn_pipe.sv
// gf180mcu_fd_sc_mcu9t5v0__andn_pipe: pipelined NIN-input AND/NAND tree with accumulator and registered output
module gf180mcu_fd_sc_mcu9t5v0__andn_pipe
  import gf180mcu_fd_sc_mcu9t5v0__andn_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int NIN   = 2,
  parameter int PIPE  = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                    VDD,
  inout  wire                    VSS,
`endif
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NIN*WIDTH-1:0]   A,
  input  logic                   VALID_IN,
  input  logic [1:0]             MODE,
  input  logic                   EN,
  input  logic                   CLR,
  output logic [WIDTH-1:0]       Z,
  output logic                   VALID_OUT
);
  localparam int LV = clog2(NIN);
  // the last level stays combinational so the output register completes the latency
  for (genvar i = 0; i < LV; i++) begin : g_lvl
    localparam int NI = lvl_n(NIN, i);
    localparam int NO = lvl_n(NIN, i + 1);
    logic [NI*WIDTH-1:0] a;
    logic v, vo;
    mode_e m, mo;
    logic [NO*WIDTH-1:0] z;
    if (i == 0) begin : g_in
      assign a = A;
      assign v = VALID_IN;
      assign m = mode_e'(MODE);
    end else begin : g_nx
      assign a = g_lvl[i-1].z;
      assign v = g_lvl[i-1].vo;
      assign m = g_lvl[i-1].mo;
    end
    gf180mcu_fd_sc_mcu9t5v0__andn_stage #(
      .WIDTH(WIDTH),
      .N    (NI),
      .REG  ((PIPE != 0) && (i < LV - 1))
    ) u_stage (
      .clk    (CLK),
      .rst    (RST),
      .en_i   (EN),
      .a_i    (a),
      .valid_i(v),
      .mode_i (m),
      .z_o    (z),
      .valid_o(vo),
      .mode_o (mo)
    );
  end
  logic [WIDTH-1:0] r, z_d, z_q, acc_d, acc_q, acc_b, acc_r, res;
  logic fv, acc_m, inv_m, valid_q;
  mode_e fm;
  assign r = g_lvl[LV-1].z;
  assign fv = g_lvl[LV-1].vo;
  assign fm = g_lvl[LV-1].mo;
  // clear-then-load: CLR resets the base that an emerging accumulate sample ANDs into
  always_comb begin
    acc_m = (fm == MODE_ACC) || (fm == MODE_NACC);
    inv_m = (fm == MODE_NAND) || (fm == MODE_NACC);
    acc_b = CLR ? '1 : acc_q;
    acc_r = acc_b & r;
    res = acc_m ? acc_r : r;
    z_d = fv ? (inv_m ? ~res : res) : z_q;
    acc_d = (fv && acc_m) ? acc_r : acc_b;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      z_q <= '0;
      acc_q <= '1;
      valid_q <= 1'b0;
    end else if (EN) begin
      z_q <= z_d;
      acc_q <= acc_d;
      valid_q <= fv;
    end
  assign Z = z_q;
  assign VALID_OUT = valid_q;
`ifndef FUNCTIONAL
  specify
    (CLK *> Z) = (0, 0);
    (CLK *> VALID_OUT) = (0, 0);
  endspecify
`endif
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__andn_pipe.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__andn_pipe: directed checks of the AND tree for NIN=4/3 and PIPE=1/0
module tb_gf180mcu_fd_sc_mcu9t5v0__andn_pipe;
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, en = 1'b1, clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [31:0] a4 = '0;
  logic [23:0] a3 = '0;
  logic [7:0] z0, z1, z2;
  logic v0, v1, v2;
  int total = 0, bad = 0;
  logic [7:0] acc_x [3] = '{8'hF7, 8'h7F, 8'hFE};
  logic [7:0] acc_z [3] = '{8'hF7, 8'h77, 8'h76};
  logic       st_en [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       st_v  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] st_m  [7] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [7:0] st_x  [7] = '{8'h11, 8'h22, 8'h44, 8'h44, 8'h44, 8'h00, 8'h00};
  logic       st_vo [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] st_z  [7] = '{8'h00, 8'h11, 8'h11, 8'h11, 8'hDD, 8'h44, 8'h44};
  always #5 clk = ~clk;
  gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(.WIDTH(8), .NIN(4), .PIPE(1)) u0 (
    .CLK(clk), .RST(rst), .A(a4), .VALID_IN(valid_in), .MODE(mode), .EN(en), .CLR(clr), .Z(z0), .VALID_OUT(v0));
  gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(.WIDTH(8), .NIN(3), .PIPE(1)) u1 (
    .CLK(clk), .RST(rst), .A(a3), .VALID_IN(valid_in), .MODE(mode), .EN(en), .CLR(clr), .Z(z1), .VALID_OUT(v1));
  gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(.WIDTH(8), .NIN(4), .PIPE(0)) u2 (
    .CLK(clk), .RST(rst), .A(a4), .VALID_IN(valid_in), .MODE(mode), .EN(en), .CLR(clr), .Z(z2), .VALID_OUT(v2));
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] x);
    valid_in = v;
    mode = m;
    a4 = {8'hFF, 8'hFF, 8'hFF, x};
    a3 = {8'hFF, 8'hFF, x};
  endtask
  initial begin
    #2;
    chk("rst_z0", z0, 8'h00);
    chk("rst_v0", 8'(v0), 8'h0);
    chk("rst_z1", z1, 8'h00);
    chk("rst_z2", z2, 8'h00);
    step();
    rst = 1'b0;
    valid_in = 1'b1;
    mode = 2'b00;
    a4 = 32'hFF3CF0FF;
    a3 = 24'h3CF0FF;
    step();
    valid_in = 1'b0;
    chk("and_lat_v0", 8'(v0), 8'h0);
    chk("and_lat_v1", 8'(v1), 8'h0);
    chk("and_p0_v2", 8'(v2), 8'h1);
    chk("and_p0_z2", z2, 8'h30);
    step();
    chk("and_v0", 8'(v0), 8'h1);
    chk("and_z0", z0, 8'h30);
    chk("and_n3_v1", 8'(v1), 8'h1);
    chk("and_n3_z1", z1, 8'h30);
    chk("and_p0_once", 8'(v2), 8'h0);
    step();
    chk("and_once_v0", 8'(v0), 8'h0);
    chk("and_hold_z0", z0, 8'h30);
    valid_in = 1'b1;
    mode = 2'b01;
    step();
    valid_in = 1'b0;
    chk("nand_p0_z2", z2, 8'hCF);
    step();
    chk("nand_z0", z0, 8'hCF);
    chk("nand_n3_z1", z1, 8'hCF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, 2'b10, acc_x[i]);
      else drive(1'b0, 2'b10, 8'hFF);
      step();
      if (i >= 1) begin
        chk($sformatf("acc%0d_v0", i - 1), 8'(v0), 8'h1);
        chk($sformatf("acc%0d_z0", i - 1), z0, acc_z[i-1]);
      end
    end
    step();
    chk("acc_end_v0", 8'(v0), 8'h0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive(1'b1, 2'b10, 8'h01);
    step();
    valid_in = 1'b0;
    step();
    chk("acc01_z0", z0, 8'h01);
    drive(1'b1, 2'b10, 8'h0F);
    step();
    valid_in = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clrload_v0", 8'(v0), 8'h1);
    chk("clrload_z0", z0, 8'h0F);
    drive(1'b1, 2'b10, 8'hFF);
    step();
    valid_in = 1'b0;
    step();
    chk("clrload_acc", z0, 8'h0F);
    for (int i = 0; i < 7; i++) begin
      en = st_en[i];
      drive(st_v[i], st_m[i], st_x[i]);
      step();
      chk($sformatf("stall%0d_v0", i), 8'(v0), 8'(st_vo[i]));
      if (i >= 1) chk($sformatf("stall%0d_z0", i), z0, st_z[i]);
    end
    en = 1'b1;
    drive(1'b1, 2'b00, 8'h5A);
    step();
    drive(1'b1, 2'b00, 8'hA5);
    step();
    chk("pre_rst_z0", z0, 8'h5A);
    rst = 1'b1;
    valid_in = 1'b0;
    #1;
    chk("mid_rst_z0", z0, 8'h00);
    chk("mid_rst_v0", 8'(v0), 8'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d_v0", i), 8'(v0), 8'h0);
    end
    drive(1'b1, 2'b10, 8'hFF);
    step();
    valid_in = 1'b0;
    chk("rst_acc_lat", 8'(v0), 8'h0);
    step();
    chk("rst_acc_v0", 8'(v0), 8'h1);
    chk("rst_acc_z0", z0, 8'hFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
